// File: rtl/sha256_nonce_block_feeder_pkg.sv
// Shared definitions for the SHA-256 second-block nonce feeder.
//   SHA256_PAD_WORD : the '1' padding bit that follows the 640-bit header message
//   feed_state_t    : feeder FSM encoding (IDLE / RUN / DONE)
//   *_MSB           : most significant bit of each field inside the 512-bit block
//   pack_block()    : assembles {tail, nonce, pad word, zeros, length}
package sha256_nonce_block_feeder_pkg;

    localparam logic [31:0] SHA256_PAD_WORD = 32'h8000_0000;

    typedef enum logic [1:0] {
        FEED_IDLE = 2'd0,
        FEED_RUN  = 2'd1,
        FEED_DONE = 2'd2
    } feed_state_t;

    localparam int TAIL_MSB  = 511;
    localparam int NONCE_MSB = 415;
    localparam int PAD_MSB   = 383;
    localparam int LEN_MSB   = 63;

    // Fields not written here stay zero: that is the 288-bit zero gap
    // between the pad word and the length field.
    function automatic logic [511:0] pack_block(
        input logic [95:0] tail,
        input logic [31:0] nonce,
        input logic [63:0] len
    );
        logic [511:0] blk;
        blk = '0;
        blk[TAIL_MSB  -: 96] = tail;
        blk[NONCE_MSB -: 32] = nonce;
        blk[PAD_MSB   -: 32] = SHA256_PAD_WORD;
        blk[LEN_MSB   -: 64] = len;
        return blk;
    endfunction

endpackage

// File: rtl/sha256_nonce_counter.sv
// Nonce generator and remaining-block counter for the nonce block feeder.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   load         : capture nonce_start / nonce_count (load has priority over step)
//   step         : advance nonce by NONCE_STEP and decrement remaining
//   nonce_start  : first nonce of the range
//   nonce_count  : number of blocks minus one
//   nonce        : current (not yet emitted) nonce
//   last         : the current nonce is the final one of the range
module sha256_nonce_counter #(
    parameter logic [31:0] NONCE_STEP = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] nonce_start,
    input  logic [31:0] nonce_count,
    output logic [31:0] nonce,
    output logic        last
);

    logic [31:0] nonce_reg;
    // One bit wider than nonce_count so the full 2^32-block range never
    // looks finished early; termination never looks at the nonce value.
    logic [32:0] remaining_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nonce_reg     <= '0;
            remaining_reg <= '0;
        end else if (load) begin
            nonce_reg     <= nonce_start;
            remaining_reg <= {1'b0, nonce_count};
        end else if (step) begin
            nonce_reg     <= nonce_reg + NONCE_STEP;   // wraps mod 2^32
            remaining_reg <= remaining_reg - 33'd1;
        end
    end

    assign nonce = nonce_reg;
    assign last  = (remaining_reg == 33'd0);

endmodule

// File: rtl/sha256_nonce_block_feeder.sv
// Feeds fully padded 512-bit second header blocks, one per cycle, into the
// first W-schedule stage of the mining core.
// Optional build macro: SHA_FEED_STALL_EN adds a `stall` input that pauses
// emission without losing the pending nonce.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   load         : start pulse, honoured only in IDLE
//   abort        : stop emission and return to IDLE (beats load and stall)
//   stall        : (SHA_FEED_STALL_EN only) hold emission while in RUN
//   tail_in      : {merkle_tail, ntime, nbits}
//   nonce_start  : first nonce
//   nonce_count  : blocks to emit minus one
//   write_en     : block_out / nonce_out valid this cycle
//   block_out    : {tail, nonce, 32'h80000000, 288'b0, LEN_BITS}
//   nonce_out    : nonce carried in block_out
//   busy         : high while in RUN
//   done         : one-cycle pulse after the last block of a completed range
module sha256_nonce_block_feeder
    import sha256_nonce_block_feeder_pkg::*;
#(
    parameter logic [31:0] NONCE_STEP = 32'd1,
    parameter int unsigned LEN_BITS   = 640
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         abort,
`ifdef SHA_FEED_STALL_EN
    input  logic         stall,
`endif
    input  logic [95:0]  tail_in,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_count,
    output logic         write_en,
    output logic [511:0] block_out,
    output logic [31:0]  nonce_out,
    output logic         busy,
    output logic         done
);

    localparam logic [63:0] LEN_FIELD = 64'(LEN_BITS);

    feed_state_t  state_reg;
    logic [95:0]  tail_reg;
    logic         write_en_reg;
    logic [511:0] block_reg;
    logic [31:0]  nonce_out_reg;
    logic         busy_reg;
    logic         done_reg;

    logic         stall_active;
    logic         cnt_load;
    logic         cnt_step;
    logic [31:0]  cnt_nonce;
    logic         cnt_last;

`ifdef SHA_FEED_STALL_EN
    assign stall_active = stall;
`else
    assign stall_active = 1'b0;
`endif

    // Counter controls are decoded from the same conditions the FSM uses,
    // so the counter advances exactly on the edges that emit a block.
    assign cnt_load = (state_reg == FEED_IDLE) && load && !abort;
    assign cnt_step = (state_reg == FEED_RUN) && !abort && !stall_active;

    sha256_nonce_counter #(
        .NONCE_STEP (NONCE_STEP)
    ) u_counter (
        .clk         (clk),
        .rst         (rst),
        .load        (cnt_load),
        .step        (cnt_step),
        .nonce_start (nonce_start),
        .nonce_count (nonce_count),
        .nonce       (cnt_nonce),
        .last        (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= FEED_IDLE;
            tail_reg      <= '0;
            write_en_reg  <= 1'b0;
            block_reg     <= '0;
            nonce_out_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                FEED_IDLE: begin
                    write_en_reg <= 1'b0;
                    done_reg     <= 1'b0;
                    if (cnt_load) begin
                        tail_reg  <= tail_in;
                        busy_reg  <= 1'b1;
                        state_reg <= FEED_RUN;
                    end
                end
                FEED_RUN: begin
                    done_reg <= 1'b0;
                    if (abort) begin
                        write_en_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        state_reg    <= FEED_IDLE;
                    end else if (stall_active) begin
                        // block_out/nonce_out keep the last emitted block
                        write_en_reg <= 1'b0;
                    end else begin
                        write_en_reg  <= 1'b1;
                        block_reg     <= pack_block(tail_reg, cnt_nonce, LEN_FIELD);
                        nonce_out_reg <= cnt_nonce;
                        if (cnt_last) begin
                            busy_reg  <= 1'b0;
                            state_reg <= FEED_DONE;
                        end
                    end
                end
                FEED_DONE: begin
                    // The last block is on the outputs now; an abort seen
                    // here cancels the completion pulse.
                    write_en_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    done_reg     <= !abort;
                    state_reg    <= FEED_IDLE;
                end
                default: begin
                    write_en_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    done_reg     <= 1'b0;
                    state_reg    <= FEED_IDLE;
                end
            endcase
        end
    end

    assign write_en  = write_en_reg;
    assign block_out = block_reg;
    assign nonce_out = nonce_out_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule
